// File: rtl/cv32e40x_xif_cpx_tracker_pkg.sv
// Shared types for the eXtension-interface coprocessor tracking buffer.
// Holds the per-entry lifecycle state and a helper that maps a commit-channel kill bit to a state.
package cv32e40x_xif_cpx_tracker_pkg;

  typedef enum logic [1:0] {
    ENTRY_FREE      = 2'd0,
    ENTRY_ISSUED    = 2'd1,
    ENTRY_COMMITTED = 2'd2,
    ENTRY_KILLED    = 2'd3
  } entry_state_e;

  function automatic entry_state_e resolve_state(input logic kill);
    return kill ? ENTRY_KILLED : ENTRY_COMMITTED;
  endfunction

endpackage

// File: rtl/cv32e40x_xif_cpx_out_reg.sv
// One-deep valid/ready output register.
// A new word can be loaded whenever the register is empty or is being drained this cycle.
module cv32e40x_xif_cpx_out_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             can_load_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample their inputs from the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign can_load_o = !valid_q || ready_i;
  assign valid_o    = valid_q;
  assign data_o     = data_q;

endmodule

// File: rtl/cv32e40x_xif_cpx_tracker.sv
// In-order tracker for offloaded instructions: records issues, resolves commit/kill,
// collects in-order FU results and retires committed results in issue order.
module cv32e40x_xif_cpx_tracker
  import cv32e40x_xif_cpx_tracker_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_WIDTH   = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [X_ID_WIDTH-1:0]        issue_id_i,
  input  logic [RD_WIDTH-1:0]          issue_rd_i,
  input  logic                         commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]        commit_id_i,
  input  logic                         commit_kill_i,
  input  logic                         fu_res_valid_i,
  output logic                         fu_res_ready_o,
  input  logic [X_ID_WIDTH-1:0]        fu_res_id_i,
  input  logic [DATA_WIDTH-1:0]        fu_res_data_i,
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic [X_ID_WIDTH-1:0]        result_id_o,
  output logic [RD_WIDTH-1:0]          result_rd_o,
  output logic [DATA_WIDTH-1:0]        result_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned OUT_W = X_ID_WIDTH + RD_WIDTH + DATA_WIDTH;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [RD_WIDTH-1:0]   rd;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    entry_state_e          state;
  } entry_t;

  entry_t           entries_q [DEPTH];
  entry_t           entries_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] dat_ptr_q, dat_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             issue_fire, fu_fire;
  logic             cmt_hit, cmt_new, cmt_err;
  logic [PTR_W-1:0] cmt_idx, scan_idx;
  entry_t           head;
  entry_state_e     head_state;
  logic             drop, emit, retire;
  logic             out_can_load;
  logic [OUT_W-1:0] out_data;

  assign issue_ready_o  = cnt_q < CNT_W'(DEPTH);
  assign issue_fire     = issue_valid_i && issue_ready_o;
  // The data pointer always sits on the oldest entry still waiting for FU data.
  assign fu_res_ready_o = (entries_q[dat_ptr_q].state != ENTRY_FREE) && !entries_q[dat_ptr_q].data_valid;
  assign fu_fire        = fu_res_valid_i && fu_res_ready_o;

  // Oldest-first search so a re-issued id never steals the commit of its older twin.
  always_comb begin
    cmt_hit  = 1'b0;
    cmt_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PTR_W'(i);
      if (!cmt_hit && entries_q[scan_idx].state == ENTRY_ISSUED
          && entries_q[scan_idx].id == commit_id_i) begin
        cmt_hit = 1'b1;
        cmt_idx = scan_idx;
      end
    end
  end

  assign cmt_new = commit_valid_i && !cmt_hit && issue_fire && (issue_id_i == commit_id_i);
  assign cmt_err = commit_valid_i && !cmt_hit && !cmt_new;

  // A commit hitting the head is forwarded so a head with data already present retires this cycle.
  always_comb begin
    head       = entries_q[rd_ptr_q];
    head_state = head.state;
    if (commit_valid_i && cmt_hit && cmt_idx == rd_ptr_q) begin
      head_state = resolve_state(commit_kill_i);
    end
  end

  assign drop   = (head_state == ENTRY_KILLED) && head.data_valid;
  assign emit   = (head_state == ENTRY_COMMITTED) && head.data_valid && out_can_load;
  assign retire = drop || emit;

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    dat_ptr_d = dat_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q + CNT_W'(issue_fire) - CNT_W'(retire);
    err_d     = cmt_err || (fu_fire && fu_res_id_i != entries_q[dat_ptr_q].id);

    if (issue_fire) begin
      entries_d[wr_ptr_q].id         = issue_id_i;
      entries_d[wr_ptr_q].rd         = issue_rd_i;
      entries_d[wr_ptr_q].data       = '0;
      entries_d[wr_ptr_q].data_valid = 1'b0;
      entries_d[wr_ptr_q].state      = cmt_new ? resolve_state(commit_kill_i) : ENTRY_ISSUED;
      wr_ptr_d                       = wr_ptr_q + PTR_W'(1);
    end
    if (commit_valid_i && cmt_hit) begin
      entries_d[cmt_idx].state = resolve_state(commit_kill_i);
    end
    if (fu_fire) begin
      entries_d[dat_ptr_q].data       = fu_res_data_i;
      entries_d[dat_ptr_q].data_valid = 1'b1;
      dat_ptr_d                       = dat_ptr_q + PTR_W'(1);
    end
    if (retire) begin
      entries_d[rd_ptr_q].state      = ENTRY_FREE;
      entries_d[rd_ptr_q].data_valid = 1'b0;
      rd_ptr_d                       = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the entry array is reset because its state/data_valid fields are control, not just payload.
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      dat_ptr_q <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      dat_ptr_q <= dat_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  cv32e40x_xif_cpx_out_reg #(
    .WIDTH (OUT_W)
  ) u_out_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (emit),
    .data_i     ({head.id, head.rd, head.data}),
    .ready_i    (result_ready_i),
    .can_load_o (out_can_load),
    .valid_o    (result_valid_o),
    .data_o     (out_data)
  );

  assign {result_id_o, result_rd_o, result_data_o} = out_data;
  assign occupancy_o = cnt_q;
  assign err_o       = err_q;

endmodule
